crp16_mem_arbiter: RTL and testbench
====================================

Name: crp16_mem_arbiter

Overview:
Two-master, round-robin arbiter sharing one dual_mem port between the crp16 datapath and a second requester, such as a program loader or debug reader. The arbiter serializes accesses and registers the memory address, data and write-enable outputs. It returns read data with a valid pulse. It sits between the requesters and one memory port at processor top level.

Parameters:
ADDR_W, 16, address width of the masters and the memory port
DATA_W, 16, data width of the masters and the memory port
READ_LAT, 1, cycles from registered address to valid mem_q (1..4)

Ports:
clock  in  1  system clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 access request; held until m0_gnt
m0_wren  in  1  master 0 write (1) / read (0)
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_gnt  out  1  one-cycle pulse: master 0 request accepted
m0_rvalid  out  1  one-cycle pulse: m0_rdata valid
m0_rdata  out  DATA_W  master 0 read data
m1_req, m1_wren, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as m0_*, for master 1
mem_address  out  ADDR_W  memory port address (registered)
mem_data  out  DATA_W  memory port write data (registered)
mem_wren  out  1  memory port write enable (registered)
mem_q  in  DATA_W  memory port read data

Behaviour:
- Reset (reset low, asynchronous): the following all go to 0:
  - state = IDLE
  - all gnt and rvalid outputs
  - both rdata outputs
  - mem_address, mem_data, mem_wren
  - priority pointer = master 0
- States: IDLE, ACCESS, RWAIT.
- IDLE:
  - If neither request is set: stay in IDLE; mem_wren = 0; mem_address and mem_data hold their values.
  - If exactly one request is set: that master wins.
  - If both requests are set: the master named by the priority pointer wins.
  - On the winning edge:
    - register the winner's addr/wdata/wren into mem_*
    - pulse the winner's gnt for exactly one cycle
    - latch the winner ID and the read/write type
    - set the priority pointer to the other master
    - go to ACCESS.
- ACCESS (1 cycle): mem_* hold their values.
  - Write: on the next edge clear mem_wren and return to IDLE. A write occupies 2 cycles, request to next possible grant.
  - Read: go to RWAIT with latency counter = READ_LAT-1.
- RWAIT:
  - Each cycle, decrement the counter.
  - At counter 0: capture mem_q into the winner's rdata, pulse its rvalid for one cycle, return to IDLE.
  - Read turnaround: the grant edge, then READ_LAT+1 further cycles until rvalid.
- The non-winning master's rdata holds its old value. rvalid never pulses for writes.
- Masters keep req high until they see gnt.
  - Dropping req before gnt cancels the request with no memory side-effect.
  - addr/wdata/wren are sampled only on the grant edge and may change afterwards.
- Requests arriving while in ACCESS/RWAIT are not sampled. They are arbitrated on return to IDLE; there is no request queue.
- Fairness: with both masters requesting continuously, grants alternate m0, m1, m0, … Neither master waits longer than one other access.
- gnt pulses for the two masters are never both set in the same cycle. Likewise the two rvalid pulses.
- Reset asserted mid-access:
  - the in-flight access is aborted
  - no rvalid is produced
  - mem_wren drops immediately (asynchronously).
- The memory is clocked on the inverted clock. READ_LAT counts system clock cycles from mem_address being registered to mem_q being stable at the next rising edge.

Test Plan:
- Reset release, no requests for 10 cycles -> mem_wren=0, gnt/rvalid stay 0, mem_address=0x0000.
- m0 write addr 0x0012 data 0xBEEF, then m0 read 0x0012 (READ_LAT=1) -> m0_gnt pulses on each grant; mem_wren=1 for one ACCESS cycle; m0_rvalid pulses 2 cycles after the read grant with m0_rdata=0xBEEF.
- m0_req and m1_req both held high for 4 reads from reset -> grant order m0, m1, m0, m1; each rvalid goes to the matching master; the other master's rdata is unchanged.
- m1 read issued while an m0 read is in RWAIT -> m1 granted in the cycle after m0_rvalid, never earlier; m0 data is uncorrupted.
- m0_req raised for 1 cycle during an m1 access, then dropped -> no m0 grant, no memory write.
- reset pulled low during RWAIT of an m1 read -> no m1_rvalid; all outputs 0; after release, first simultaneous request grants m0.

Source files
------------

// File: rtl/crp16_mem_arbiter.sv
// crp16_mem_arbiter: two-master round-robin arbiter sharing one dual_mem port
// Ports: clock, reset (async active-low); m0_*/m1_* requesters (req, wren, addr, wdata in;
// gnt, rvalid, rdata out); mem_address/mem_data/mem_wren registered memory drive; mem_q read data.
module crp16_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wren,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wren,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);
  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT} state_t;
  localparam logic [1:0] LAT_M1 = 2'(READ_LAT - 1);
  state_t state, state_nx;
  logic ptr, ptr_nx, win, win_nx, rd, rd_nx, pick;
  logic [1:0] cnt, cnt_nx;
  logic [ADDR_W-1:0] address_nx;
  logic [DATA_W-1:0] data_nx, rdata0_nx, rdata1_nx;
  logic wren_nx, gnt0_nx, gnt1_nx, rvalid0_nx, rvalid1_nx;
  // pick=1 selects master 1; the pointer only matters when both request
  assign pick = (m0_req & m1_req) ? ptr : m1_req;
  always_comb begin
    state_nx = state;
    ptr_nx = ptr;
    win_nx = win;
    rd_nx = rd;
    cnt_nx = cnt;
    address_nx = mem_address;
    data_nx = mem_data;
    wren_nx = mem_wren;
    gnt0_nx = 1'b0;
    gnt1_nx = 1'b0;
    rvalid0_nx = 1'b0;
    rvalid1_nx = 1'b0;
    rdata0_nx = m0_rdata;
    rdata1_nx = m1_rdata;
    case (state)
      IDLE: begin
        wren_nx = 1'b0;
        if (m0_req | m1_req) begin
          state_nx = ACCESS;
          win_nx = pick;
          ptr_nx = ~pick;
          rd_nx = ~(pick ? m1_wren : m0_wren);
          address_nx = pick ? m1_addr : m0_addr;
          data_nx = pick ? m1_wdata : m0_wdata;
          wren_nx = pick ? m1_wren : m0_wren;
          gnt0_nx = ~pick;
          gnt1_nx = pick;
        end
      end
      ACCESS: begin
        wren_nx = 1'b0;
        cnt_nx = LAT_M1;
        state_nx = rd ? RWAIT : IDLE;
      end
      RWAIT: begin
        if (cnt == 2'd0) begin
          state_nx = IDLE;
          rvalid0_nx = ~win;
          rvalid1_nx = win;
          rdata0_nx = win ? m0_rdata : mem_q;
          rdata1_nx = win ? mem_q : m1_rdata;
        end else begin
          cnt_nx = cnt - 2'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr <= 1'b0;
      win <= 1'b0;
      rd <= 1'b0;
      cnt <= 2'd0;
      mem_address <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
      m0_gnt <= 1'b0;
      m1_gnt <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_nx;
      ptr <= ptr_nx;
      win <= win_nx;
      rd <= rd_nx;
      cnt <= cnt_nx;
      mem_address <= address_nx;
      mem_data <= data_nx;
      mem_wren <= wren_nx;
      m0_gnt <= gnt0_nx;
      m1_gnt <= gnt1_nx;
      m0_rvalid <= rvalid0_nx;
      m1_rvalid <= rvalid1_nx;
      m0_rdata <= rdata0_nx;
      m1_rdata <= rdata1_nx;
    end
  end
endmodule

// File: tb/tb_crp16_mem_arbiter.sv
// tb_crp16_mem_arbiter: directed and randomized checks of crp16_mem_arbiter against a transaction-level model
module tb_crp16_mem_arbiter;
  localparam int RL = 1;
  logic clock = 1'b0, reset = 1'b1;
  logic m0_req = 1'b0, m0_wren = 1'b0, m1_req = 1'b0, m1_wren = 1'b0;
  logic [15:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, mem_wren;
  logic [15:0] m0_rdata, m1_rdata, mem_address, mem_data;
  logic [15:0] mem_q = '0;
  logic [15:0] mem_arr [0:255];
  logic [15:0] ref_mem [int];
  logic [15:0] exp_rd [2];
  logic ptr_m = 1'b0;
  int checks = 0, failures = 0;
  crp16_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .READ_LAT(RL)) dut (
    .clock(clock), .reset(reset),
    .m0_req(m0_req), .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );
  always #5 clock = ~clock;
  initial for (int i = 0; i < 256; i++) mem_arr[i] = '0;
  // memory on the inverted clock, as at processor top level
  always @(negedge clock) begin
    if (mem_wren) mem_arr[mem_address[7:0]] <= mem_data;
    mem_q <= mem_arr[mem_address[7:0]];
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [15:0] ref_read(input logic [15:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 16'd0;
  endfunction
  function automatic int winner(input logic r0, input logic r1);
    return (r0 && r1) ? int'(ptr_m) : (r1 ? 1 : 0);
  endfunction
  task automatic drive(input int m, input logic req, input logic wr, input logic [15:0] a, input logic [15:0] d);
    if (m == 0) begin
      m0_req = req; m0_wren = wr; m0_addr = a; m0_wdata = d;
    end else begin
      m1_req = req; m1_wren = wr; m1_addr = a; m1_wdata = d;
    end
  endtask
  task automatic do_reset();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    #1;
    chk("rst_ctl", {27'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren}, 32'd0);
    chk("rst_mem", {mem_address, mem_data}, 32'd0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 32'd0);
    repeat (2) begin
      tick();
      chk("rst_hold", {27'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren}, 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;
    ptr_m = 1'b0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
  endtask
  task automatic grant_step(input int w, input logic wr, input logic [15:0] a, input logic [15:0] d, input string tag);
    tick();
    chk({tag, "_gnt"}, {30'd0, m1_gnt, m0_gnt}, w != 0 ? 32'd2 : 32'd1);
    chk({tag, "_addr"}, {16'd0, mem_address}, {16'd0, a});
    chk({tag, "_wren"}, {31'd0, mem_wren}, {31'd0, wr});
    if (wr) chk({tag, "_wdata"}, {16'd0, mem_data}, {16'd0, d});
    chk({tag, "_rv_at_gnt"}, {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    ptr_m = (w == 0);
  endtask
  task automatic complete(input int w, input logic wr, input logic [15:0] a, input logic [15:0] d, input string tag);
    int n;
    n = wr ? 1 : RL + 1;
    if (wr) ref_mem[int'(a)] = d;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (!wr && k == n) exp_rd[w] = ref_read(a);
      chk({tag, "_rvalid"}, {30'd0, m1_rvalid, m0_rvalid},
          (!wr && k == n) ? (w != 0 ? 32'd2 : 32'd1) : 32'd0);
      chk({tag, "_busy_gnt"}, {30'd0, m1_gnt, m0_gnt}, 32'd0);
      chk({tag, "_busy_wren"}, {31'd0, mem_wren}, 32'd0);
      chk({tag, "_hold_addr"}, {16'd0, mem_address}, {16'd0, a});
      chk({tag, "_rdata"}, {m1_rdata, m0_rdata}, {exp_rd[1], exp_rd[0]});
    end
  endtask
  initial begin
    int w;
    logic [1:0] r, wv;
    logic [15:0] av [2];
    logic [15:0] dv [2];
    logic [15:0] ga, b;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    #2;
    do_reset();
    // idle after reset
    repeat (10) begin
      tick();
      chk("idle_ctl", {28'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, 32'd0);
      chk("idle_wren", {31'd0, mem_wren}, 32'd0);
      chk("idle_addr", {16'd0, mem_address}, 32'd0);
    end
    // m0 write then read back
    drive(0, 1'b1, 1'b1, 16'h0012, 16'hBEEF);
    grant_step(0, 1'b1, 16'h0012, 16'hBEEF, "wr12");
    drive(0, 1'b0, 1'b0, 16'hFFFF, 16'h0000);
    complete(0, 1'b1, 16'h0012, 16'hBEEF, "wr12");
    drive(0, 1'b1, 1'b0, 16'h0012, 16'h0000);
    grant_step(0, 1'b0, 16'h0012, 16'h0000, "rd12");
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    complete(0, 1'b0, 16'h0012, 16'h0000, "rd12");
    chk("rd12_value", {16'd0, m0_rdata}, 32'h0000BEEF);
    // randomized transactions, one or both masters requesting; the loser cancels
    for (int i = 0; i < 60; i++) begin
      r = 2'($urandom_range(1, 3));
      wv = 2'($urandom);
      for (int m = 0; m < 2; m++) begin
        av[m] = 16'($urandom_range(0, 31));
        dv[m] = 16'($urandom);
        drive(m, r[m], wv[m], av[m], dv[m]);
      end
      w = winner(r[0], r[1]);
      grant_step(w, wv[w], av[w], dv[w], "rand");
      drive(0, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      drive(1, 1'b0, 1'($urandom), 16'($urandom), 16'($urandom));
      complete(w, wv[w], av[w], dv[w], "rand");
    end
    // both masters requesting continuously from reset: grants alternate
    do_reset();
    av[0] = 16'($urandom_range(0, 31));
    av[1] = 16'($urandom_range(0, 31));
    drive(0, 1'b1, 1'b0, av[0], 16'd0);
    drive(1, 1'b1, 1'b0, av[1], 16'd0);
    for (int i = 0; i < 4; i++) begin
      w = winner(1'b1, 1'b1);
      ga = av[w];
      grant_step(w, 1'b0, ga, 16'd0, "rr");
      av[w] = 16'($urandom_range(0, 31));
      drive(w, i < 3, 1'b0, av[w], 16'd0);
      complete(w, 1'b0, ga, 16'd0, "rr");
    end
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    // m1 request arrives while m0 read is in flight
    b = 16'($urandom_range(0, 31));
    drive(0, 1'b1, 1'b0, 16'h0012, 16'd0);
    grant_step(0, 1'b0, 16'h0012, 16'd0, "ovl_m0");
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1, 1'b1, 1'b0, b, 16'd0);
    complete(0, 1'b0, 16'h0012, 16'd0, "ovl_m0");
    grant_step(1, 1'b0, b, 16'd0, "ovl_m1");
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    complete(1, 1'b0, b, 16'd0, "ovl_m1");
    // one-cycle m0 request during an m1 write is lost without side effect
    dv[1] = 16'($urandom);
    drive(1, 1'b1, 1'b1, 16'h0020, dv[1]);
    grant_step(1, 1'b1, 16'h0020, dv[1], "cancel_m1");
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(0, 1'b1, 1'b1, 16'h0055, 16'h1234);
    complete(1, 1'b1, 16'h0020, dv[1], "cancel_m1");
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    repeat (5) begin
      tick();
      chk("cancel_quiet", {27'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_wren}, 32'd0);
    end
    drive(1, 1'b1, 1'b0, 16'h0055, 16'd0);
    grant_step(1, 1'b0, 16'h0055, 16'd0, "cancel_chk");
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    complete(1, 1'b0, 16'h0055, 16'd0, "cancel_chk");
    // reset in the middle of a write and of an m1 read
    do_reset();
    drive(0, 1'b1, 1'b1, 16'h0030, 16'hAAAA);
    grant_step(0, 1'b1, 16'h0030, 16'hAAAA, "abort_wr");
    do_reset();
    drive(1, 1'b1, 1'b0, 16'h0012, 16'd0);
    grant_step(1, 1'b0, 16'h0012, 16'd0, "abort_rd");
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    tick();
    chk("abort_rd_rv", {30'd0, m1_rvalid, m0_rvalid}, 32'd0);
    do_reset();
    drive(0, 1'b1, 1'b0, 16'h0030, 16'd0);
    drive(1, 1'b1, 1'b0, 16'h0012, 16'd0);
    w = winner(1'b1, 1'b1);
    grant_step(w, 1'b0, 16'h0030, 16'd0, "post_rst");
    drive(0, 1'b0, 1'b0, 16'd0, 16'd0);
    drive(1, 1'b0, 1'b0, 16'd0, 16'd0);
    complete(w, 1'b0, 16'h0030, 16'd0, "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
